// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Boot-time program loader. Receives a byte stream (16-bit big-endian word
// count followed by the payload words, MSB first), assembles 32-bit words
// and writes them, one word per mem_we pulse, into instruction memory
// starting at ADDR_BASE. The CPU core is held in reset (cpu_rst_n low)
// until an image has been loaded successfully.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to expect one trailing
// byte after the payload, equal to the XOR of all payload bytes. A mismatch
// ends the load in the error state. Without the macro the checksum state
// and the XOR logic are not built.
//
// Parameters:
//   ADDR_BASE  byte address of the first word written (word-aligned)
//   MAX_WORDS  largest accepted word count; larger counts are a load error
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       one-cycle pulse; begins a load from IDLE, DONE or ERR
//   byte_valid  a stream byte is offered on byte_data
//   byte_data   stream byte
//   byte_ready  loader accepts a byte this cycle
//   mem_we      iMem write strobe, one cycle per word
//   mem_addr    iMem byte address of the word being written
//   mem_wdata   iMem write data
//   cpu_rst_n   active-low core reset; high only after a good load
//   busy        a load is in progress
//   done        last load succeeded (sticky until next start)
//   error       last load failed (sticky until next start)
// ---------------------------------------------------------------------------
module imem_loader #(
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_rst_n,
   output logic        busy,
   output logic        done,
   output logic        error
);

   // Word counts are 16 bits; a MAX_WORDS beyond that range simply means
   // every representable count is accepted.
   localparam logic [16:0] MAX_W = (MAX_WORDS > 32'd65535) ? 17'h1_0000
                                                           : 17'(MAX_WORDS);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_HI = 3'd1,
      S_LEN_LO = 3'd2,
      S_DATA   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK    = 3'd4,
`endif
      S_DONE   = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   state_t      state_reg;
   state_t      state_next;

   logic [7:0]  len_hi_reg;
   logic [15:0] words_left_reg;
   logic [1:0]  byte_cnt_reg;
   // Only the three leading bytes of a word need storing; the fourth byte
   // is taken straight from byte_data when the word is written out.
   logic [23:0] word_reg;
   logic [31:0] waddr_reg;
   logic        mem_we_reg;
   logic [31:0] mem_addr_reg;
   logic [31:0] mem_wdata_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  xor_reg;
`endif

   logic        byte_accept;
   logic        start_ok;
   logic        ready_int;
   logic [15:0] len_word;
   logic        len_zero;
   logic        len_too_big;
   logic        word_complete;
   logic        last_word;

   // ------------------------------------------------------------------
   // Decode helpers
   // ------------------------------------------------------------------
   assign ready_int     = (state_reg == S_LEN_HI) || (state_reg == S_LEN_LO)
`ifdef IMEM_LOADER_CHECKSUM_EN
                       || (state_reg == S_CHK)
`endif
                       || (state_reg == S_DATA);
   assign byte_accept   = byte_valid && ready_int;
   // start is ignored while a load is running
   assign start_ok      = start && ((state_reg == S_IDLE) ||
                                    (state_reg == S_DONE) ||
                                    (state_reg == S_ERR));
   assign len_word      = {len_hi_reg, byte_data};
   assign len_zero      = (len_word == 16'd0);
   assign len_too_big   = ({1'b0, len_word} > MAX_W);
   assign word_complete = (byte_cnt_reg == 2'd3);
   assign last_word     = (words_left_reg == 16'd1);

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_next = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (byte_accept) begin
               state_next = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (byte_accept) begin
               if (len_zero) begin
                  // empty image: nothing to write and no checksum byte
                  state_next = S_DONE;
               end else if (len_too_big) begin
                  state_next = S_ERR;
               end else begin
                  state_next = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (byte_accept && word_complete && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_next = S_CHK;
`else
               state_next = S_DONE;
`endif
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHK: begin
            if (byte_accept) begin
               state_next = (byte_data == xor_reg) ? S_DONE : S_ERR;
            end
         end
`endif
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs decoded from the current state. done/error are sticky
   // because the DONE/ERR states persist until the next start.
   // ------------------------------------------------------------------
   always_comb begin
      byte_ready = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      cpu_rst_n  = 1'b0;
      case (state_reg)
         S_LEN_HI, S_LEN_LO, S_DATA: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHK: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
         end
`endif
         S_DONE: begin
            done      = 1'b1;
            cpu_rst_n = 1'b1;
         end
         S_ERR: begin
            error = 1'b1;
         end
         default: begin
            byte_ready = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Length capture and word counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_hi_reg     <= 8'd0;
         words_left_reg <= 16'd0;
      end else begin
         if (state_reg == S_LEN_HI && byte_accept) begin
            len_hi_reg <= byte_data;
         end
         if (state_reg == S_LEN_LO && byte_accept) begin
            words_left_reg <= len_word;
         end else if (state_reg == S_DATA && byte_accept && word_complete) begin
            words_left_reg <= words_left_reg - 16'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Word assembly and iMem write port. The write is registered so that
   // mem_we/mem_addr/mem_wdata are all valid in the cycle after the edge
   // that accepted the fourth byte of a word.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt_reg  <= 2'd0;
         word_reg      <= 24'd0;
         waddr_reg     <= ADDR_BASE;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= ADDR_BASE;
         mem_wdata_reg <= 32'd0;
      end else begin
         mem_we_reg <= 1'b0;
         if (start_ok) begin
            byte_cnt_reg <= 2'd0;
            waddr_reg    <= ADDR_BASE;
         end else if (state_reg == S_DATA && byte_accept) begin
            word_reg     <= {word_reg[15:0], byte_data};
            byte_cnt_reg <= byte_cnt_reg + 2'd1;   // wraps to 0 after byte 4
            if (word_complete) begin
               mem_we_reg    <= 1'b1;
               mem_addr_reg  <= waddr_reg;
               mem_wdata_reg <= {word_reg, byte_data};
               waddr_reg     <= waddr_reg + 32'd4;  // modulo 2^32
            end
         end
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   // ------------------------------------------------------------------
   // Running XOR of payload bytes only (length bytes excluded)
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xor_reg <= 8'd0;
      end else if (start_ok) begin
         xor_reg <= 8'd0;
      end else if (state_reg == S_DATA && byte_accept) begin
         xor_reg <= xor_reg ^ byte_data;
      end
   end
`endif

   assign mem_we    = mem_we_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. Expected iMem writes are pushed to a
// scoreboard queue as each word is driven and popped/compared when mem_we
// is seen. Status outputs are checked at fixed points after each load.
// Define IMEM_LOADER_CHECKSUM_EN for both files to exercise the checksum.
// ---------------------------------------------------------------------------
module tb_imem_loader;

   localparam logic [31:0] BASE = 32'hFFFF_FFF8;   // wraps during a load
   localparam int          MAXW = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'd0;
   logic        byte_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_rst_n;
   logic        busy;
   logic        done;
   logic        error;

   imem_loader #(
      .ADDR_BASE (BASE),
      .MAX_WORDS (MAXW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cpu_rst_n  (cpu_rst_n),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         sb[$];
   logic [31:0] img[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_writes = 0;

   task automatic check_value(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // write monitor / scoreboard consumer
   always @(negedge clk) begin
      if (rst_n && mem_we) begin
         wr_t w;
         n_writes++;
         if (sb.size() == 0) begin
            check_value("unexpected_we", 32'(sb.size()), 32'd1);
         end else begin
            w = sb.pop_front();
            $display("write addr=%h data=%h (expected %h/%h)", mem_addr, mem_wdata,
                     w.addr, w.data);
            check_value("wr_addr", mem_addr, w.addr);
            check_value("wr_data", mem_wdata, w.data);
         end
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic idle_cycle();
      byte_valid = 1'b0;
      @(negedge clk);
   endtask

   // Offer one byte; returns at the negedge after the accepting edge.
   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         check_value("ready_timeout", 32'(byte_ready), 32'd1);
      end
      @(posedge clk);
      @(negedge clk);
      byte_valid = 1'b0;
      $display("byte %h sent", b);
   endtask

   // Send length + img payload (+ checksum). Expected writes are queued.
   task automatic run_load(input bit gaps, input bit mid_start);
      logic [15:0] n = 16'(img.size());
      logic [31:0] a = BASE;
      logic [7:0]  x = 8'd0;
      logic [7:0]  b;
      send_byte(n[15:8]);
      if (gaps) idle_cycle();
      send_byte(n[7:0]);
      if (mid_start) begin
         pulse_start();
         check_value("busy_after_mid_start", 32'(busy), 32'd1);
      end
      foreach (img[i]) begin
         wr_t w;
         w.addr = a;
         w.data = img[i];
         sb.push_back(w);
         a = a + 32'd4;
         for (int k = 3; k >= 0; k--) begin
            if (gaps) idle_cycle();
            b = img[i][8*k +: 8];
            x = x ^ b;
            send_byte(b);
         end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (n != 16'd0) begin
         if (gaps) idle_cycle();
         send_byte(x);
      end
`endif
   endtask

   task automatic check_done(input string tag);
      check_value({tag, "_done"}, 32'(done), 32'd1);
      check_value({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd1);
      check_value({tag, "_error"}, 32'(error), 32'd0);
      check_value({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic drain(input string tag);
      @(negedge clk);
      #1;
      check_value({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check_value({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
      check_value({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      check_value({tag, "_mem_addr"}, mem_addr, BASE);
      check_value({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      check_value({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
      check_value({tag, "_busy"}, 32'(busy), 32'd0);
      check_value({tag, "_done"}, 32'(done), 32'd0);
      check_value({tag, "_error"}, 32'(error), 32'd0);
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      // ---- reset state
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // ---- back-to-back two-word load (address wraps past 2^32)
      img = '{32'h1122_3344, 32'hAABB_CCDD};
      w0 = n_writes;
      pulse_start();
      check_value("ready_after_start", 32'(byte_ready), 32'd1);
      check_value("cpu_rst_during_load", 32'(cpu_rst_n), 32'd0);
      run_load(1'b0, 1'b0);
      check_done("b2b");
      drain("b2b");
      check_value("b2b_writes", 32'(n_writes - w0), 32'd2);

      // ---- same image with gaps in byte_valid
      w0 = n_writes;
      pulse_start();
      check_value("gaps_done_cleared", 32'(done), 32'd0);
      run_load(1'b1, 1'b0);
      check_done("gaps");
      drain("gaps");
      check_value("gaps_writes", 32'(n_writes - w0), 32'd2);

      // ---- oversized count 257
      w0 = n_writes;
      pulse_start();
      send_byte(8'h01);
      send_byte(8'h01);
      check_value("big_error", 32'(error), 32'd1);
      check_value("big_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      check_value("big_ready", 32'(byte_ready), 32'd0);
      drain("big");
      check_value("big_writes", 32'(n_writes - w0), 32'd0);
      pulse_start();
      check_value("restart_clears_error", 32'(error), 32'd0);

      // ---- zero count (already in LEN_HI after the start above)
      w0 = n_writes;
      send_byte(8'h00);
      send_byte(8'h00);
      check_done("zero");
      drain("zero");
      check_value("zero_writes", 32'(n_writes - w0), 32'd0);

      // ---- start coincident with byte_valid, then start while busy
      start      = 1'b1;
      byte_valid = 1'b1;
      byte_data  = 8'h00;
      check_value("coincident_ready", 32'(byte_ready), 32'd0);
      @(negedge clk);
      start      = 1'b0;
      byte_valid = 1'b0;
      check_value("coincident_busy", 32'(busy), 32'd1);
      img = '{32'hDEAD_BEEF};
      w0 = n_writes;
      run_load(1'b0, 1'b1);
      check_done("midstart");
      drain("midstart");
      check_value("midstart_writes", 32'(n_writes - w0), 32'd1);

      // ---- reset after byte 6 of a two-word load
      img = '{32'h0102_0304, 32'h0506_0708};
      begin
         wr_t w;
         w.addr = BASE;
         w.data = 32'h0102_0304;
         sb.push_back(w);
      end
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h02);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h04);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_value("midreset_sb", 32'(sb.size()), 32'd0);
      pulse_start();
      run_load(1'b0, 1'b0);
      check_done("after_reset");
      drain("after_reset");

      // ---- MAX_WORDS boundary: exactly 256 words accepted
      img.delete();
      for (int i = 0; i < MAXW; i++) begin
         img.push_back(32'(i) * 32'h0101_0101 ^ 32'h5A00_00A5);
      end
      w0 = n_writes;
      pulse_start();
      run_load(1'b0, 1'b0);
      check_done("max");
      drain("max");
      check_value("max_writes", 32'(n_writes - w0), 32'd256);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // ---- bad checksum: 00 01 01 02 03 04 05
      begin
         wr_t w;
         w.addr = BASE;
         w.data = 32'h0102_0304;
         sb.push_back(w);
      end
      w0 = n_writes;
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h04);
      check_value("chk_waiting_busy", 32'(busy), 32'd1);
      send_byte(8'h05);
      check_value("badchk_error", 32'(error), 32'd1);
      check_value("badchk_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      drain("badchk");
      check_value("badchk_writes", 32'(n_writes - w0), 32'd1);
      // good checksum 04 for the same word
      img = '{32'h0102_0304};
      pulse_start();
      run_load(1'b0, 1'b0);
      check_done("goodchk");
      drain("goodchk");
`endif

      repeat (3) @(negedge clk);
      check_value("final_sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
